sram_responder: RTL



---
 rtl/sram_resp_pkg.sv | 30 +++
 rtl/sram_bank.sv | 35 +++
 rtl/sram_responder.sv | 106 ++++++++++
 3 files changed

// File: rtl/sram_resp_pkg.sv
// +----------------------------------------------------------------------+
// | sram_resp_pkg : shared constants and byte-merge helper for the       |
// |                 SRAM responder.                 Revision: 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

package sram_resp_pkg;

   localparam logic [15:0] MMIO_BASE_HI = 16'hbfaf;
   localparam logic [15:0] OFF_TIMER    = 16'he000;
   localparam logic [15:0] OFF_LED      = 16'hf000;
   localparam logic [15:0] OFF_SWITCH   = 16'hf004;
   localparam logic [15:0] OFF_SCRATCH  = 16'hf008;
   localparam int          BYTE_LANES   = 4;

   // Replace only the byte lanes whose enable bit is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  we);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < BYTE_LANES; i++) begin
         if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_bank.sv
// +----------------------------------------------------------------------+
// | sram_bank : single-port RAM, byte-lane writes, registered read port. |
// |                                                 Revision: 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module sram_bank
   import sram_resp_pkg::*;
#(
   parameter int RAM_AW = 16
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [BYTE_LANES-1:0] we,
   input  logic [RAM_AW-1:0]     addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] r_mem [0:(1<<RAM_AW)-1];

   // No reset here so the array and output register map onto block RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we[0]) r_mem[addr][7:0]   <= wdata[7:0];
         if (we[1]) r_mem[addr][15:8]  <= wdata[15:8];
         if (we[2]) r_mem[addr][23:16] <= wdata[23:16];
         if (we[3]) r_mem[addr][31:24] <= wdata[31:24];
         if (we == '0) rdata <= r_mem[addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/sram_responder.sv
// +----------------------------------------------------------------------+
// | sram_responder : RAM plus MMIO window (timer, LED, switch, scratch)  |
// |                  answering the core's data_sram port. Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module sram_responder
   import sram_resp_pkg::*;
#(
   parameter int RAM_AW = 16,
   parameter int LED_W  = 16,
   parameter int SW_W   = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              sram_en,
   input  logic [3:0]        sram_we,
   input  logic [31:0]       sram_addr,
   input  logic [31:0]       sram_wdata,
   output logic [31:0]       sram_rdata,
   output logic [LED_W-1:0]  led,
   input  logic [SW_W-1:0]   switch
);

   logic              w_is_mmio;
   logic [15:0]       w_off;
   logic              w_rd;
   logic              w_mmio_wr;
   logic [31:0]       w_ram_q;
   logic [31:0]       w_mmio_rd;

   logic [31:0]       r_timer;
   logic [LED_W-1:0]  r_led;
   logic [31:0]       r_scratch;
   logic [SW_W-1:0]   r_sw_meta;
   logic [SW_W-1:0]   r_sw_sync;
   logic [31:0]       r_mmio_rdata;
   logic              r_sel_ram;

   assign w_is_mmio = (sram_addr[31:16] == MMIO_BASE_HI);
   assign w_off     = sram_addr[15:0];
   assign w_rd      = sram_en && (sram_we == 4'b0000);
   assign w_mmio_wr = sram_en && (sram_we != 4'b0000) && w_is_mmio;

   sram_bank #(
      .RAM_AW (RAM_AW)
   ) u_bank (
      .clk   (clk),
      .en    (sram_en && !w_is_mmio),
      .we    (sram_we),
      .addr  (sram_addr[RAM_AW+1:2]),
      .wdata (sram_wdata),
      .rdata (w_ram_q)
   );

   always_comb begin
      w_mmio_rd = 32'h0;
      case (w_off)
         OFF_TIMER:   w_mmio_rd = r_timer;
         OFF_LED:     w_mmio_rd = 32'(r_led);
         OFF_SWITCH:  w_mmio_rd = 32'(r_sw_sync);
         OFF_SCRATCH: w_mmio_rd = r_scratch;
         default:     w_mmio_rd = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_timer      <= 32'h0;
         r_led        <= '1;
         r_scratch    <= 32'h0;
         r_sw_meta    <= '0;
         r_sw_sync    <= '0;
         r_mmio_rdata <= 32'h0;
         r_sel_ram    <= 1'b0;
      end else begin
         r_sw_meta <= switch;
         r_sw_sync <= r_sw_meta;

         // A timer write takes the place of that cycle's increment.
         if (w_mmio_wr && (w_off == OFF_TIMER))
            r_timer <= byte_merge(r_timer, sram_wdata, sram_we);
         else
            r_timer <= r_timer + 32'd1;

         // LED only spans byte lanes 0 and 1.
         if (w_mmio_wr && (w_off == OFF_LED))
            r_led <= LED_W'(byte_merge(32'(r_led), sram_wdata, sram_we & 4'b0011));

         if (w_mmio_wr && (w_off == OFF_SCRATCH))
            r_scratch <= byte_merge(r_scratch, sram_wdata, sram_we);

         // Select bit steers the output mux to whichever source the last read hit.
         if (w_rd) begin
            r_sel_ram <= !w_is_mmio;
            if (w_is_mmio) r_mmio_rdata <= w_mmio_rd;
         end
      end
   end

   assign sram_rdata = r_sel_ram ? w_ram_q : r_mmio_rdata;
   assign led        = r_led;

endmodule

`default_nettype wire
